conv_frame_ctrl: RTL and testbench
==================================

// Module: conv_frame_ctrl
// PURPOSE
//  Frame sequencer for the 3x3 Sobel convolution datapath. Accepts a raster pixel stream (valid/ready)
//  and drives the convolution's shift-enable and data inputs. Primes and flushes the line buffers so
//  every frame is processed in isolation. Keeps only results whose window lies fully inside the frame,
//  tags each with output (row,col), and pulses frame-done.
// PARAMETERS
//  N          3    kernel size; must match the convolution instance
//  DATA_WIDTH 12   input pixel width; result width is DATA_WIDTH+3
//  IMG_W      640  frame width in pixels (>= N)
//  IMG_H      480  frame height in pixels (>= N)
//  LAT_PIX    IMG_W*(N-1)+N-1  convolution latency, counted in shift advances
// PORTS
//  i_clk        in   1        clock
//  i_rst_n      in   1        async active-low reset
//  i_start      in   1        frame start pulse; ignored unless IDLE
//  i_pix_valid  in   1        input pixel valid
//  i_pix        in   DW       input pixel
//  o_pix_ready  out  1        input pixel accepted when valid&ready
//  o_conv_en    out  1        to convolution i_val_valid (one advance per high cycle)
//  o_conv_val   out  DW       to convolution i_val
//  i_conv_valid in   1        from convolution o_val_valid
//  i_conv_val   in   DW+3     from convolution o_val
//  o_res_valid  out  1        kept-result strobe
//  o_res        out  DW+3     kept result
//  o_res_row    out  clog2(IMG_H) row of kept result, 0..IMG_H-N
//  o_res_col    out  clog2(IMG_W) col of kept result, 0..IMG_W-N
//  o_busy       out  1        high in any state except IDLE
//  o_frame_done out  1        1-cycle pulse after the last kept result
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; all counters 0. Reset mid-frame aborts the frame with no done pulse.
//  Datapath contract: one i_conv_valid per advance once primed. The result of input k returns with
//   advance k+LAT_PIX.
//  FSM: IDLE -i_start-> RUN. RUN -(IMG_W*IMG_H pixels accepted)-> FLUSH. FLUSH -(LAT_PIX advances)-> DONE.
//   DONE -> IDLE after 1 cycle, which is the o_frame_done cycle.
//  RUN: o_pix_ready=1. o_conv_en = i_pix_valid. o_conv_val = i_pix, combinational pass-through.
//   Pixel counter increments per accept.
//  FLUSH: o_pix_ready=0. o_conv_en=1 every cycle with o_conv_val=0. Flush counter increments per advance.
//  IDLE/DONE: o_pix_ready=0, o_conv_en=0.
//  Result path: adv counter counts i_conv_valid pulses while busy and saturates at LAT_PIX+IMG_W*IMG_H.
//  - The first LAT_PIX pulses of each frame are stale or priming data and are discarded.
//  - Pulse j (j = count-LAT_PIX, 0-based) is the window with bottom-right pixel at
//    (r,c) = (j/IMG_W, j%IMG_W), tracked with row/col counters, no divider.
//  - Kept iff r>=N-1 and c>=N-1. Then o_res_row=r-(N-1), o_res_col=c-(N-1), o_res=i_conv_val.
//  - Windows wrapping across a row boundary (c<N-1) are dropped.
//  Output timing: o_res* registered, one cycle after the i_conv_valid pulse.
//   Kept results per frame = (IMG_W-N+1)*(IMG_H-N+1).
//  No output backpressure; the consumer must accept every o_res_valid.
//  Column counter wraps IMG_W-1 -> 0 and increments the row counter. Row stops at IMG_H-1.
//  i_start while busy is ignored. i_pix_valid outside RUN is not accepted (ready=0).
//  Input gaps in RUN: no advance is issued, and counters hold.
//  o_frame_done: asserted in DONE only. DONE is entered only when the final result has been registered.
// TESTING
//  1) IMG_W=5, IMG_H=4, N=3, ramp pixels 0..19, contiguous -> 6 results.
//     Row/col pairs (0,0)..(1,2) in raster order; values match the Sobel reference model; one done pulse.
//  2) Same frame with i_pix_valid toggling 1,0,1,0 -> identical results. o_conv_en high only on accepts.
//  3) Two back-to-back frames, second all 4095 -> second frame results are all 0.
//     No stale data from frame 1 (first LAT_PIX pulses discarded).
//  4) i_start pulsed during RUN and FLUSH -> ignored. Exactly 20 accepts and LAT_PIX flush advances.
//  5) Assert i_rst_n low after 10 pixels -> all outputs 0 next edge, IDLE, no done.
//     A fresh frame then runs correctly.
//  6) Constant-column image (pixel = col*100) -> every kept o_res = 800.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for the 3x3 Sobel convolution datapath.
// Feeds a raster pixel stream into the convolution, flushes its line buffers with zeros,
// keeps only results whose window lies fully inside the frame and tags them with (row,col).
module conv_frame_ctrl #(
    parameter int unsigned N          = 3,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned LAT_PIX    = IMG_W * (N - 1) + N - 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_pix_valid,
    input  logic [DATA_WIDTH-1:0]    i_pix,
    output logic                     o_pix_ready,
    output logic                     o_conv_en,
    output logic [DATA_WIDTH-1:0]    o_conv_val,
    input  logic                     i_conv_valid,
    input  logic [DATA_WIDTH+2:0]    i_conv_val,
    output logic                     o_res_valid,
    output logic [DATA_WIDTH+2:0]    o_res,
    output logic [$clog2(IMG_H)-1:0] o_res_row,
    output logic [$clog2(IMG_W)-1:0] o_res_col,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int unsigned RW      = $clog2(IMG_H);
    localparam int unsigned CW      = $clog2(IMG_W);
    localparam int unsigned NPIX    = IMG_W * IMG_H;
    localparam int unsigned ADV_SAT = LAT_PIX + NPIX;
    localparam int unsigned PW      = $clog2(NPIX + 1);
    localparam int unsigned FW      = $clog2(LAT_PIX + 1);
    localparam int unsigned AW      = $clog2(ADV_SAT + 1);

    localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'(LAT_PIX);
    localparam logic [AW-1:0] ADV_PRIME = AW'(LAT_PIX);
    localparam logic [AW-1:0] ADV_END   = AW'(ADV_SAT);
    localparam logic [RW-1:0] ROW_MIN   = RW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN   = CW'(N - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pix_cnt_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [AW-1:0]   adv_cnt_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            start_frame;
    logic            adv_live;
    logic            adv_past_prime;
    logic            keep;

    assign start_frame    = (state_q == StIdle) && i_start;
    // Pulses after saturation or outside a frame are not part of this frame's result stream.
    assign adv_live       = (state_q != StIdle) && i_conv_valid && (adv_cnt_q != ADV_END);
    assign adv_past_prime = adv_cnt_q >= ADV_PRIME;
    assign keep           = adv_live && adv_past_prime && (row_q >= ROW_MIN) && (col_q >= COL_MIN);

    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = (state_q == StDone);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and convolution-side drive.
    always_comb begin
        state_d     = state_q;
        o_pix_ready = 1'b0;
        o_conv_en   = 1'b0;
        o_conv_val  = '0;
        case (state_q)
            StIdle: begin
                if (i_start) state_d = StRun;
            end
            StRun: begin
                o_pix_ready = 1'b1;
                o_conv_en   = i_pix_valid;
                o_conv_val  = i_pix;
                if (i_pix_valid && (pix_cnt_q == PIX_LAST)) state_d = StFlush;
            end
            StFlush: begin
                o_conv_en = (flush_cnt_q != FLUSH_END);
                // Leave only once the final result pulse has been registered.
                if ((flush_cnt_q == FLUSH_END) && (adv_cnt_q == ADV_END)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pixel and flush advance counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else if (start_frame) begin
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == StRun) && i_pix_valid) pix_cnt_q <= pix_cnt_q + PW'(1);
            if ((state_q == StFlush) && o_conv_en) flush_cnt_q <= flush_cnt_q + FW'(1);
        end
    end

    // Result-pulse counter and bottom-right (row,col) tracker for the current window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            adv_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else if (start_frame) begin
            adv_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else if (adv_live) begin
            adv_cnt_q <= adv_cnt_q + AW'(1);
            if (adv_past_prime) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    if (row_q != ROW_LAST) row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Registered result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_valid <= 1'b0;
            o_res       <= '0;
            o_res_row   <= '0;
            o_res_col   <= '0;
        end else begin
            o_res_valid <= keep;
            if (keep) begin
                o_res     <= i_conv_val;
                o_res_row <= row_q - ROW_MIN;
                o_res_col <= col_q - COL_MIN;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: scoreboard bench for conv_frame_ctrl with a behavioural Sobel datapath.
module tb_conv_frame_ctrl;

    localparam int N    = 3;
    localparam int DW   = 12;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int LAT  = W * (N - 1) + N - 1;
    localparam int NPIX = W * H;
    localparam int NRES = (W - N + 1) * (H - N + 1);

    logic                     i_clk;
    logic                     i_rst_n;
    logic                     i_start;
    logic                     i_pix_valid;
    logic [DW-1:0]            i_pix;
    logic                     o_pix_ready;
    logic                     o_conv_en;
    logic [DW-1:0]            o_conv_val;
    logic                     i_conv_valid;
    logic [DW+2:0]            i_conv_val;
    logic                     o_res_valid;
    logic [DW+2:0]            o_res;
    logic [$clog2(H)-1:0]     o_res_row;
    logic [$clog2(W)-1:0]     o_res_col;
    logic                     o_busy;
    logic                     o_frame_done;

    conv_frame_ctrl #(
        .N(N), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .LAT_PIX(LAT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_pix_valid(i_pix_valid), .i_pix(i_pix), .o_pix_ready(o_pix_ready),
        .o_conv_en(o_conv_en), .o_conv_val(o_conv_val),
        .i_conv_valid(i_conv_valid), .i_conv_val(i_conv_val),
        .o_res_valid(o_res_valid), .o_res(o_res), .o_res_row(o_res_row),
        .o_res_col(o_res_col), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef int win_t [0:2][0:2];
    typedef struct {
        int row;
        int col;
        int val;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_total = 0;
    int   acc_total = 0;
    int   res_total = 0;
    int   done_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // |Gx|+|Gy| over a 3x3 window, w[row][col] with row 0 on top.
    function automatic int sobel(input win_t w);
        int gx;
        int gy;
        gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
        gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) & 32'h7FFF;
    endfunction

    // Convolution stand-in: one output per advance, one cycle later. The output of advance a is
    // the window whose bottom-right pixel is input a-LAT; the history is never cleared.
    int sr [0:2*LAT];
    initial begin
        bit     en;
        int     v;
        win_t   w;
        for (int i = 0; i <= 2 * LAT; i++) sr[i] = 0;
        i_conv_valid = 1'b0;
        i_conv_val   = '0;
        forever begin
            @(negedge i_clk);
            en = o_conv_en;
            v  = int'(o_conv_val);
            @(posedge i_clk);
            #1;
            if (en) begin
                for (int i = 2 * LAT; i > 0; i--) sr[i] = sr[i-1];
                sr[0] = v;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w[dr][dc] = sr[LAT + (2 - dr) * W + (2 - dc)];
                i_conv_valid = 1'b1;
                i_conv_val   = 15'(sobel(w));
            end else begin
                i_conv_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every result and checks the stream-side rules.
    initial begin
        res_t e;
        bit   prev_res_valid;
        prev_res_valid = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_conv_en) en_total++;
                if (o_pix_ready && i_pix_valid) acc_total++;
                if (o_pix_ready) begin
                    chk("run_en_follows_valid", o_conv_en, i_pix_valid);
                    if (i_pix_valid) chk("run_val_pass", o_conv_val, i_pix);
                end else if (o_conv_en) begin
                    chk("flush_val_zero", o_conv_val, 0);
                    chk("flush_busy", o_busy, 1);
                end
                if (o_res_valid) begin
                    res_total++;
                    if (exp_q.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_row", o_res_row, e.row);
                        chk("res_col", o_res_col, e.col);
                        chk("res_val", o_res, e.val);
                    end
                end
                if (o_frame_done) begin
                    done_total++;
                    chk("done_after_last_res", prev_res_valid, 1);
                    chk("done_drained", exp_q.size(), 0);
                end
                prev_res_valid = o_res_valid;
            end else begin
                prev_res_valid = 1'b0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, o_pix_ready, 0);
        chk({tag, "_conv_en"}, o_conv_en, 0);
        chk({tag, "_conv_val"}, o_conv_val, 0);
        chk({tag, "_res_valid"}, o_res_valid, 0);
        chk({tag, "_res"}, o_res, 0);
        chk({tag, "_res_row"}, o_res_row, 0);
        chk({tag, "_res_col"}, o_res_col, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_frame_done, 0);
    endtask

    // mode: 0 ramp, 1 all 4095, 2 col*100, 3 random. gap_mode: 0 none, 1 alternate, 2 random.
    // abort_at >= 0 resets the block after that many accepted pixels.
    task automatic run_frame(input int mode, input int gap_mode, input bit poke, input int abort_at);
        int   img [0:H-1][0:W-1];
        win_t w;
        res_t r;
        int   idx, cyc, en0, acc0, res0, done0;
        bit   acc;
        bit   v;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       img[y][x] = y * W + x;
                    1:       img[y][x] = 4095;
                    2:       img[y][x] = x * 100;
                    default: img[y][x] = int'($urandom_range(0, 4095));
                endcase
        if (abort_at < 0) begin
            for (int y = 0; y <= H - N; y++)
                for (int x = 0; x <= W - N; x++) begin
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            w[dr][dc] = img[y + dr][x + dc];
                    r.row = y;
                    r.col = x;
                    r.val = sobel(w);
                    if (mode == 2) chk("const_col_800", r.val, 800);
                    exp_q.push_back(r);
                end
        end
        en0 = en_total; acc0 = acc_total; res0 = res_total; done0 = done_total;
        @(posedge i_clk); #1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < NPIX && cyc < 1000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            i_pix_valid = v;
            i_pix       = DW'(img[idx / W][idx % W]);
            i_start     = poke && (cyc == 5 || cyc == 9);
            @(negedge i_clk);
            acc = i_pix_valid && o_pix_ready;
            @(posedge i_clk); #1;
            if (acc) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) break;
        end
        i_pix_valid = 1'b0;
        i_pix       = '0;
        i_start     = 1'b0;
        if (cyc >= 1000) chk("pix_timeout", idx, NPIX);
        if (abort_at >= 0) begin
            #2 i_rst_n = 1'b0;
            @(negedge i_clk);
            chk_all_zero("abort");
            @(posedge i_clk); #1;
            i_rst_n = 1'b1;
            repeat (5) @(posedge i_clk);
            #1;
            chk("abort_no_done", done_total - done0, 0);
            chk("abort_idle", o_busy, 0);
            return;
        end
        if (poke) begin
            repeat (3) @(posedge i_clk);
            #1 i_start = 1'b1;
            @(posedge i_clk);
            #1 i_start = 1'b0;
        end
        cyc = 0;
        while (done_total == done0 && cyc < 400) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        if (cyc >= 400) chk("done_timeout", done_total - done0, 1);
        repeat (3) @(posedge i_clk);
        #1;
        chk("done_pulses", done_total - done0, 1);
        chk("accepts", acc_total - acc0, NPIX);
        chk("conv_advances", en_total - en0, NPIX + LAT);
        chk("kept_results", res_total - res0, NRES);
        chk("idle_after_done", o_busy, 0);
        exp_q.delete();
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
        i_pix       = '0;
        repeat (2) @(negedge i_clk);
        chk_all_zero("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        run_frame(0, 0, 1'b0, -1);  // contiguous ramp
        run_frame(0, 1, 1'b0, -1);  // ramp with alternating gaps
        run_frame(0, 0, 1'b0, -1);  // back-to-back pair, second saturated
        run_frame(1, 0, 1'b0, -1);
        run_frame(0, 0, 1'b1, -1);  // start pokes during RUN and FLUSH
        run_frame(3, 0, 1'b0, 10);  // reset mid-frame
        repeat (3) @(posedge i_clk);
        #1;
        run_frame(0, 0, 1'b0, -1);  // fresh frame after abort
        run_frame(2, 0, 1'b0, -1);  // constant-column image
        for (int k = 0; k < 3; k++) run_frame(3, 2, 1'b0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
